npc_ctrl: RTL and testbench

Multi-cycle sequencer for the NPC core. It steps one instruction at a time through fetch, decode, execute, memory and writeback, and drives the instruction-memory and data-memory handshakes. It also generates the write enables for the IR, PC and register file. It consumes the one-hot class vectors produced by the instruction decoder and owns the core's halt state.

---
 rtl/npc_ctrl.sv | 116 +++++++++++
 tb/tb_npc_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the NPC core.
// Optional perf counters are built only when YSYX_23060251_PERF_EN is defined.
module npc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] opinfo_i,
  input  logic [1:0]  sys_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_resp_valid_i,
  output logic        dmem_req_valid_o,
  output logic        dmem_req_we_o,
  input  logic        dmem_req_ready_i,
  input  logic        dmem_resp_valid_i,
  output logic        ir_we_o,
  output logic        reg_we_o,
  output logic        pc_we_o,
  output logic        halt_o,
  output logic        halt_code_o,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o
);

  typedef enum logic [3:0] {
    StIdle, StFetch, StIwait, StDecode, StExec, StMreq, StMwait, StWb, StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] op_q, op_d;
  logic [1:0]  sys_q, sys_d;
  logic        halt_code_q, halt_code_d;
  logic        op_onehot;

  assign op_onehot = (opinfo_i != 12'h000) && ((opinfo_i & (opinfo_i - 12'd1)) == 12'h000);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sys_d       = sys_q;
    halt_code_d = halt_code_q;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (imem_req_ready_i) state_d = StIwait;
      StIwait:  if (imem_resp_valid_i) state_d = StDecode;
      StDecode: begin
        op_d  = opinfo_i;
        sys_d = sys_i;
        if (!op_onehot) begin
          state_d     = StHalt;
          halt_code_d = 1'b1;
        end else if (opinfo_i[11] && sys_i[1]) begin
          state_d     = StHalt;
          halt_code_d = 1'b0;
        end else begin
          state_d = StExec;
        end
      end
      StExec:   state_d = (op_q[7] || op_q[8]) ? StMreq : StWb;
      StMreq:   if (dmem_req_ready_i) state_d = StMwait;
      StMwait:  if (dmem_resp_valid_i) state_d = StWb;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 12'h000;
      sys_q       <= 2'b00;
      halt_code_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sys_q       <= sys_d;
      halt_code_q <= halt_code_d;
    end
  end

  // Only a few latched class bits steer later states; the rest are kept for visibility.
  logic unused_latched;
  assign unused_latched = ^{op_q, sys_q};

  always_comb begin
    imem_req_valid_o = (state_q == StFetch);
    ir_we_o          = (state_q == StIwait) && imem_resp_valid_i;
    dmem_req_valid_o = (state_q == StMreq);
    dmem_req_we_o    = (state_q == StMreq) && op_q[8];
    pc_we_o          = (state_q == StWb);
    reg_we_o         = (state_q == StWb) && !(op_q[8] || op_q[4] || op_q[11]);
    halt_o           = (state_q == StHalt);
    halt_code_o      = halt_code_q;
  end

`ifdef YSYX_23060251_PERF_EN
  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 64'h0;
      instret_q <= 64'h0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (state_q == StWb) instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;
`else
  assign cycle_cnt_o = 64'h0;
  assign instret_o   = 64'h0;
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// Scoreboard bench for npc_ctrl: per-instruction expectations are queued at issue
// and retired by a monitor when the controller reaches writeback.
module tb_npc_ctrl;

`ifdef YSYX_23060251_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] opinfo_i;
  logic [1:0]  sys_i;
  logic        imem_req_valid_o, imem_req_ready_i, imem_resp_valid_i;
  logic        dmem_req_valid_o, dmem_req_we_o, dmem_req_ready_i, dmem_resp_valid_i;
  logic        ir_we_o, reg_we_o, pc_we_o, halt_o, halt_code_o;
  logic [63:0] cycle_cnt_o, instret_o;

  npc_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .opinfo_i         (opinfo_i),
    .sys_i            (sys_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_resp_valid_i(imem_resp_valid_i),
    .dmem_req_valid_o (dmem_req_valid_o),
    .dmem_req_we_o    (dmem_req_we_o),
    .dmem_req_ready_i (dmem_req_ready_i),
    .dmem_resp_valid_i(dmem_resp_valid_i),
    .ir_we_o          (ir_we_o),
    .reg_we_o         (reg_we_o),
    .pc_we_o          (pc_we_o),
    .halt_o           (halt_o),
    .halt_code_o      (halt_code_o),
    .cycle_cnt_o      (cycle_cnt_o),
    .instret_o        (instret_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rwe;
    logic mem;
    logic we;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  logic        mem_seen = 1'b0;
  logic [63:0] exp_ret  = 64'd0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {imem_req_valid_o, dmem_req_valid_o, dmem_req_we_o, ir_we_o,
            reg_we_o, pc_we_o, halt_o, halt_code_o};
  endfunction

  // Retire queued expectations when writeback is observed.
  always @(negedge clk) begin
    exp_t cur;
    if (rst) begin
      mem_seen = 1'b0;
    end else begin
      if (dmem_req_valid_o) begin
        mem_seen = 1'b1;
        if (exp_q.size() == 0) check_eq("dmem_unexp", 64'(exp_q.size()), 64'd1);
        else check_eq("dmem_we", 64'(dmem_req_we_o), 64'(exp_q[0].we));
      end
      if (pc_we_o) begin
        if (exp_q.size() == 0) begin
          check_eq("wb_unexp", 64'(exp_q.size()), 64'd1);
        end else begin
          cur = exp_q.pop_front();
          check_eq("wb_reg_we", 64'(reg_we_o), 64'(cur.rwe));
          check_eq("wb_mem", 64'(mem_seen), 64'(cur.mem));
        end
        mem_seen = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", 64'(outs()), 64'd0);
    check_eq("rst_cycle", cycle_cnt_o, 64'd0);
    check_eq("rst_instret", instret_o, 64'd0);
    exp_q.delete();
    exp_ret = 64'd0;
  endtask

  // Leaves the bench at the negedge of the IDLE cycle; the next cycle is FETCH.
  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("idle_outs", 64'(outs()), 64'd0);
  endtask

  task automatic run_instr(input string tag, input logic [11:0] op, input logic [1:0] sys,
                           input logic rwe, input logic mem, input logic we, input int stall);
    exp_t e;
    int   n = 0, vcnt = 0, ircnt = 0;
    bit   done = 1'b0;
    e.rwe = rwe;
    e.mem = mem;
    e.we  = we;
    exp_q.push_back(e);
    opinfo_i         = op;
    sys_i            = sys;
    dmem_req_ready_i = (stall == 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check_eq({tag, "_fetch"}, 64'(imem_req_valid_o), 64'd1);
        check_eq({tag, "_instret"}, instret_o, Perf ? exp_ret : 64'd0);
      end
      n++;
      if (ir_we_o) ircnt++;
      if (dmem_req_valid_o) begin
        vcnt++;
        if (vcnt == stall + 1) dmem_req_ready_i = 1'b1;
      end
      if (pc_we_o) begin
        done = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_lat"}, 64'(n), 64'((mem ? 7 : 5) + stall));
    check_eq({tag, "_irwe"}, 64'(ircnt), 64'd1);
    check_eq({tag, "_vcnt"}, 64'(vcnt), 64'(mem ? stall + 1 : 0));
    dmem_req_ready_i = 1'b1;
    exp_ret++;
  endtask

  task automatic run_halt(input string tag, input logic [11:0] op, input logic [1:0] sys,
                          input logic code, input int freeze);
    int          n = 0;
    bit          done = 1'b0;
    logic [63:0] c0;
    do_reset();
    opinfo_i = op;
    sys_i    = sys;
    release_rst();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (halt_o) begin
        done = 1'b1;
        break;
      end
    end
    check_eq({tag, "_halted"}, 64'(done), 64'd1);
    check_eq({tag, "_lat"}, 64'(n), 64'd4);
    check_eq({tag, "_code"}, 64'(halt_code_o), 64'(code));
    check_eq({tag, "_cycle"}, cycle_cnt_o, Perf ? 64'd4 : 64'd0);
    c0 = cycle_cnt_o;
    for (int i = 0; i < freeze; i++) begin
      @(negedge clk);
      imem_resp_valid_i = ~imem_resp_valid_i;
      dmem_resp_valid_i = ~dmem_resp_valid_i;
      check_eq({tag, "_frozen"}, 64'(outs()), 64'({6'b0, 1'b1, code}));
    end
    if (freeze > 0)
      check_eq({tag, "_cycle_run"}, cycle_cnt_o - c0, Perf ? 64'(freeze) : 64'd0);
    imem_resp_valid_i = 1'b1;
    dmem_resp_valid_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst               = 1'b1;
    opinfo_i          = 12'h001;
    sys_i             = 2'b00;
    imem_req_ready_i  = 1'b1;
    imem_resp_valid_i = 1'b1;
    dmem_req_ready_i  = 1'b1;
    dmem_resp_valid_i = 1'b1;

    do_reset();
    release_rst();
    run_instr("alu",    12'h001, 2'b00, 1'b1, 1'b0, 1'b0, 0);
    run_instr("load",   12'h080, 2'b00, 1'b1, 1'b1, 1'b0, 4);
    run_instr("store",  12'h100, 2'b00, 1'b0, 1'b1, 1'b1, 0);
    run_instr("branch", 12'h010, 2'b00, 1'b0, 1'b0, 1'b0, 0);
    run_instr("ecall",  12'h800, 2'b01, 1'b0, 1'b0, 1'b0, 0);
    run_instr("jal",    12'h020, 2'b00, 1'b1, 1'b0, 1'b0, 0);

    // Reset while a load waits for its response; the transaction is abandoned.
    exp_q.push_back(exp_t'{rwe: 1'b1, mem: 1'b1, we: 1'b0});
    opinfo_i          = 12'h080;
    dmem_resp_valid_i = 1'b0;
    seen              = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) check_eq("mid_instret", instret_o, Perf ? exp_ret : 64'd0);
      if (dmem_req_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("mid_mreq", 64'(seen), 64'd1);
    @(negedge clk);
    check_eq("mwait_outs", 64'(outs()), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_outs", 64'(outs()), 64'd0);
    check_eq("mid_rst_cycle", cycle_cnt_o, 64'd0);
    check_eq("mid_rst_instret", instret_o, 64'd0);
    exp_q.delete();
    exp_ret           = 64'd0;
    imem_req_ready_i  = 1'b0;
    dmem_resp_valid_i = 1'b1;
    release_rst();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("late_resp", 64'({imem_req_valid_o, dmem_req_valid_o, reg_we_o, pc_we_o}),
               64'd8);
    end
    imem_req_ready_i = 1'b1;

    run_halt("ebreak", 12'h800, 2'b10, 1'b0, 100);
    run_halt("ill_zero", 12'h000, 2'b00, 1'b1, 0);
    run_halt("ill_multi", 12'h003, 2'b00, 1'b1, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
